// File: rtl/fifo_merge_ctrl.sv
// Merge-stage controller: drains two ascending (or descending) sorted-run FIFOs
// into one merged run in an output FIFO, from a start pulse to a done pulse.
module fifo_merge_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  run_len_a,
    input  logic [LEN_W-1:0]  run_len_b,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] a_dout,
    input  logic              a_empty,
    output logic              a_rd_en,
    input  logic [DATA_W-1:0] b_dout,
    input  logic              b_empty,
    output logic              b_rd_en,
    output logic [DATA_W-1:0] out_din,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic [LEN_W-1:0]  out_count
);

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] head_a_r;
    logic [DATA_W-1:0] head_b_r;
    logic              va_r;
    logic              vb_r;
    logic              pa_r;
    logic              pb_r;
    logic [LEN_W-1:0]  rem_a_r;
    logic [LEN_W-1:0]  rem_b_r;
    logic [LEN_W-1:0]  count_r;
    logic              merge_s;
    logic              exh_a_s;
    logic              exh_b_s;
    logic              a_first_s;
    logic              cons_a_s;
    logic              cons_b_s;
    logic              rd_a_s;
    logic              rd_b_s;
    logic              launch_s;
    logic [DATA_W-1:0] din_s;

    // Compare, read-issue, output select and next-state decode
    always_comb begin
        state_nxt_s = state_r;
        din_s       = DATA_ZERO;
        merge_s     = (state_r == ST_MERGE);
        launch_s    = (state_r == ST_IDLE) && start;
        exh_a_s     = (rem_a_r == LEN_ZERO) && !pa_r && !va_r;
        exh_b_s     = (rem_b_r == LEN_ZERO) && !pb_r && !vb_r;
        // Ties go to A so equal keys keep their run order
        if (DESCEND) begin
            a_first_s = (head_a_r >= head_b_r);
        end else begin
            a_first_s = (head_a_r <= head_b_r);
        end
        cons_a_s = !rst && merge_s && !out_full && va_r && (exh_b_s || (vb_r && a_first_s));
        cons_b_s = !rst && merge_s && !out_full && vb_r && (exh_a_s || (va_r && !a_first_s));
        rd_a_s   = !rst && merge_s && (rem_a_r != LEN_ZERO) && !a_empty && !pa_r && (!va_r || cons_a_s);
        rd_b_s   = !rst && merge_s && (rem_b_r != LEN_ZERO) && !b_empty && !pb_r && (!vb_r || cons_b_s);
        if (cons_a_s) begin
            din_s = head_a_r;
        end else if (cons_b_s) begin
            din_s = head_b_r;
        end else begin
            din_s = DATA_ZERO;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_MERGE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MERGE: begin
                if (exh_a_s && exh_b_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MERGE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Side A: remaining count, read-pending flag and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_a_r  <= LEN_ZERO;
            pa_r     <= 1'b0;
            va_r     <= 1'b0;
            head_a_r <= DATA_ZERO;
        end else begin
            if (launch_s) begin
                rem_a_r <= run_len_a;
            end else if (rd_a_s) begin
                rem_a_r <= rem_a_r - LEN_ONE;
            end
            pa_r <= rd_a_s;
            if (pa_r) begin
                head_a_r <= a_dout;
                va_r     <= 1'b1;
            end else if (cons_a_s) begin
                va_r <= 1'b0;
            end
        end
    end

    // Side B: remaining count, read-pending flag and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_b_r  <= LEN_ZERO;
            pb_r     <= 1'b0;
            vb_r     <= 1'b0;
            head_b_r <= DATA_ZERO;
        end else begin
            if (launch_s) begin
                rem_b_r <= run_len_b;
            end else if (rd_b_s) begin
                rem_b_r <= rem_b_r - LEN_ONE;
            end
            pb_r <= rd_b_s;
            if (pb_r) begin
                head_b_r <= b_dout;
                vb_r     <= 1'b1;
            end else if (cons_b_s) begin
                vb_r <= 1'b0;
            end
        end
    end

    // Output element counter for the current pass
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= LEN_ZERO;
        end else if (launch_s) begin
            count_r <= LEN_ZERO;
        end else if (cons_a_s || cons_b_s) begin
            count_r <= count_r + LEN_ONE;
        end
    end

    assign a_rd_en   = rd_a_s;
    assign b_rd_en   = rd_b_s;
    assign out_wr_en = cons_a_s || cons_b_s;
    assign out_din   = din_s;
    assign busy      = merge_s;
    assign done      = (state_r == ST_DONE);
    assign out_count = count_r;

endmodule
